pi_req_queue: RTL and testbench

Request queue between the Pi GPIO register interface and the 68000 bus-cycle engine. It captures Pi register writes into staging registers and pushes a complete request into a small FIFO on every ADDR_HI write. It presents the FIFO head to the bus engine over a valid/ready handshake with at most one request in flight. It returns read data and busy/overflow status for the Pi. This lets the Pi post back-to-back writes without polling busy between them.

---
 rtl/pi_req_queue.sv | 171 +++++++++++++++++
 tb/tb_pi_req_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_req_queue.sv
// Request queue between the Pi register interface and the 68000 bus-cycle engine.
// Pi writes are staged, then pushed as a complete request on every ADDR_HI write.
module pi_req_queue #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        sys_clk,
  input  logic        nRESET,
  input  logic        pi_wr_strobe,
  input  logic [2:0]  pi_a,
  input  logic [15:0] pi_data_in,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [23:0] req_addr,
  output logic [1:0]  req_size,
  output logic        req_read,
  output logic [2:0]  req_fc,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        full,
  output logic        overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  localparam logic [2:0] REG_DATA_LO = 3'd0;
  localparam logic [2:0] REG_DATA_HI = 3'd1;
  localparam logic [2:0] REG_ADDR_LO = 3'd2;
  localparam logic [2:0] REG_ADDR_HI = 3'd3;
  localparam logic [2:0] REG_CLR_OVF = 3'd5;

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  size;
    logic        read;
    logic [2:0]  fc;
    logic [31:0] wdata;
  } req_t;

  req_t                  r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_inflight;
  logic                  r_inflight_read;
  logic [31:0]           r_stage_wdata;
  logic [15:0]           r_stage_addr_lo;
  logic [31:0]           r_rdata;
  logic                  r_busy;
  logic                  r_full;
  logic                  r_overflow;

  logic                  w_empty;
  logic                  w_full_now;
  logic                  w_pop;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_clr_ovf;
  req_t                  w_new;
  req_t                  w_head;
  req_t                  w_head_vis;
  logic [DEPTH_LOG2:0]   w_count_next;
  logic                  w_inflight_next;

  assign w_empty    = (r_count == '0);
  assign w_full_now = (r_count == CNT_FULL);
  assign w_pop      = req_valid & req_ready;
  assign w_push_req = pi_wr_strobe & (pi_a == REG_ADDR_HI);
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full_now | w_pop);
  assign w_drop     = w_push_req & w_full_now & ~w_pop;
  assign w_clr_ovf  = pi_wr_strobe & (pi_a == REG_CLR_OVF);

  assign w_new = '{addr:  {pi_data_in[7:0], r_stage_addr_lo},
                   size:  pi_data_in[9:8],
                   read:  pi_data_in[10],
                   fc:    pi_data_in[13:11],
                   wdata: r_stage_wdata};

  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_vis = w_empty ? '0 : w_head;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_count_next    = r_count;
    w_inflight_next = r_inflight;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
    if (w_pop) begin
      w_inflight_next = 1'b1;
    end else if (rsp_valid) begin
      w_inflight_next = 1'b0;
    end
  end

  // NOTE: the storage array has no reset; pointers and count are reset and the head is masked while empty.
  always_ff @(posedge sys_clk) begin
    if (nRESET && w_push) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!nRESET) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_inflight      <= 1'b0;
      r_inflight_read <= 1'b0;
      r_stage_wdata   <= '0;
      r_stage_addr_lo <= '0;
      r_rdata         <= '0;
      r_busy          <= 1'b0;
      r_full          <= 1'b0;
      r_overflow      <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_inflight <= w_inflight_next;
      r_busy     <= (w_count_next != '0) | w_inflight_next;
      r_full     <= (w_count_next == CNT_FULL);

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + PTR_ONE;
        r_inflight_read <= w_head.read;
      end

      // Responses arriving with nothing in flight are stale and ignored.
      if (rsp_valid && r_inflight && r_inflight_read) begin
        r_rdata <= rsp_rdata;
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_clr_ovf) begin
        r_overflow <= 1'b0;
      end

      if (pi_wr_strobe) begin
        case (pi_a)
          REG_DATA_LO: r_stage_wdata[15:0]  <= pi_data_in;
          REG_DATA_HI: r_stage_wdata[31:16] <= pi_data_in;
          REG_ADDR_LO: r_stage_addr_lo      <= pi_data_in;
          default:     ;
        endcase
      end
    end
  end

  assign req_valid = ~w_empty & ~r_inflight;
  assign req_addr  = w_head_vis.addr;
  assign req_size  = w_head_vis.size;
  assign req_read  = w_head_vis.read;
  assign req_fc    = w_head_vis.fc;
  assign req_wdata = w_head_vis.wdata;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign full      = r_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_pi_req_queue.sv
// Bench for pi_req_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pi_req_queue;

  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic        sys_clk;
  logic        nRESET;
  logic        pi_wr_strobe;
  logic [2:0]  pi_a;
  logic [15:0] pi_data_in;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [1:0]  req_size;
  logic        req_read;
  logic [2:0]  req_fc;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] rdata;
  logic        busy;
  logic        full;
  logic        overflow;

  pi_req_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .sys_clk      (sys_clk),
    .nRESET       (nRESET),
    .pi_wr_strobe (pi_wr_strobe),
    .pi_a         (pi_a),
    .pi_data_in   (pi_data_in),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_read     (req_read),
    .req_fc       (req_fc),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rdata        (rdata),
    .busy         (busy),
    .full         (full),
    .overflow     (overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  size;
    logic        read;
    logic [2:0]  fc;
    logic [31:0] wdata;
  } req_t;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  req_t        m_q[$];
  bit          m_inflight;
  bit          m_inflight_read;
  bit          m_overflow;
  logic [31:0] m_rdata;
  logic [31:0] m_stage_wdata;
  logic [15:0] m_stage_addr_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of requests plus the in-flight flag.
  task automatic model_step();
    bit   accept;
    req_t e;
    if (!nRESET) begin
      m_q.delete();
      m_inflight      = 0;
      m_inflight_read = 0;
      m_overflow      = 0;
      m_rdata         = '0;
      m_stage_wdata   = '0;
      m_stage_addr_lo = '0;
      return;
    end
    accept = (m_q.size() != 0) && !m_inflight && (req_ready === 1'b1);
    if (accept) begin
      m_inflight      = 1;
      m_inflight_read = m_q[0].read;
      void'(m_q.pop_front());
    end else if (rsp_valid && m_inflight) begin
      if (m_inflight_read) m_rdata = rsp_rdata;
      m_inflight = 0;
    end
    if (pi_wr_strobe) begin
      case (pi_a)
        3'd0: m_stage_wdata[15:0]  = pi_data_in;
        3'd1: m_stage_wdata[31:16] = pi_data_in;
        3'd2: m_stage_addr_lo      = pi_data_in;
        3'd3: begin
          e.addr  = {pi_data_in[7:0], m_stage_addr_lo};
          e.size  = pi_data_in[9:8];
          e.read  = pi_data_in[10];
          e.fc    = pi_data_in[13:11];
          e.wdata = m_stage_wdata;
          if (m_q.size() < DEPTH) m_q.push_back(e);
          else                    m_overflow = 1;
        end
        3'd5: m_overflow = 0;
        default: ;
      endcase
    end
  endtask

  task automatic compare_outputs();
    bit exp_valid;
    exp_valid = (m_q.size() != 0) && !m_inflight;
    check("m_req_valid", req_valid, exp_valid);
    check("m_busy", busy, (m_q.size() != 0) || m_inflight);
    check("m_full", full, m_q.size() == DEPTH);
    check("m_overflow", overflow, m_overflow);
    check("m_rdata", rdata, m_rdata);
    if (exp_valid) begin
      check("m_req_addr", req_addr, m_q[0].addr);
      check("m_req_size", req_size, m_q[0].size);
      check("m_req_read", req_read, m_q[0].read);
      check("m_req_fc", req_fc, m_q[0].fc);
      check("m_req_wdata", req_wdata, m_q[0].wdata);
    end
  endtask

  initial forever begin
    @(posedge sys_clk);
    model_step();
  end

  initial forever begin
    @(negedge sys_clk);
    if (cmp_en) compare_outputs();
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic pi_wr(input logic [2:0] a, input logic [15:0] d);
    pi_wr_strobe = 1'b1;
    pi_a         = a;
    pi_data_in   = d;
    @(negedge sys_clk);
    pi_wr_strobe = 1'b0;
  endtask

  task automatic push_req(input logic [15:0] addr_lo, input logic [15:0] hi_word);
    pi_wr(3'd2, addr_lo);
    pi_wr(3'd3, hi_word);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (req_valid !== 1'b1 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("wait_req_valid", req_valid, 1'b1);
  endtask

  task automatic accept_one();
    req_ready = 1'b1;
    @(negedge sys_clk);
    req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    rsp_valid = 1'b1;
    rsp_rdata = d;
    @(negedge sys_clk);
    rsp_valid = 1'b0;
    rsp_rdata = '0;
  endtask

  initial begin
    nRESET       = 1'b0;
    pi_wr_strobe = 1'b0;
    pi_a         = '0;
    pi_data_in   = '0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_rdata    = '0;
    repeat (3) @(negedge sys_clk);
    check("reset_req_valid", req_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_full", full, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_req_addr", req_addr, 24'h0);
    nRESET = 1'b1;
    cmp_en = 1;

    // Single write: addr 0xDFF180, word, fc=5, data 0x0F00.
    pi_wr(3'd0, 16'h0F00);
    pi_wr(3'd1, 16'h0000);
    pi_wr(3'd7, 16'hFFFF);
    push_req(16'hF180, 16'h29DF);
    check("t1_req_valid", req_valid, 1'b1);
    check("t1_busy", busy, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("t1_hold_addr", req_addr, 24'hDFF180);
      check("t1_hold_wdata", req_wdata, 32'h0000_0F00);
      check("t1_hold_read", req_read, 1'b0);
      check("t1_hold_size", req_size, 2'b01);
      check("t1_hold_fc", req_fc, 3'd5);
      @(negedge sys_clk);
    end
    accept_one();
    check("t1_valid_low_after_accept", req_valid, 1'b0);
    respond(32'h0);

    // Fill to full, overflow on fifth push, then drain in order.
    for (int i = 0; i < 4; i++) push_req(16'(16'h0010 * i), 16'h2910);
    check("t2_full", full, 1'b1);
    check("t2_overflow_before", overflow, 1'b0);
    push_req(16'h0099, 16'h2910);
    check("t2_overflow_set", overflow, 1'b1);
    check("t2_full_still", full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_valid();
      check("t2_drain_addr", req_addr, {8'h10, 16'(16'h0010 * i)});
      accept_one();
      @(negedge sys_clk);
      respond(32'h0);
    end
    check("t2_busy_low", busy, 1'b0);
    check("t2_overflow_sticky", overflow, 1'b1);
    pi_wr(3'd5, 16'h0000);
    check("t2_overflow_cleared", overflow, 1'b0);

    // Long read at 0xF80000, then a write leaves rdata alone.
    push_req(16'h0000, 16'h2EF8);
    wait_valid();
    check("t3_read_bit", req_read, 1'b1);
    check("t3_size", req_size, 2'b10);
    accept_one();
    respond(32'h4AFC_4E71);
    check("t3_rdata", rdata, 32'h4AFC_4E71);
    push_req(16'hF180, 16'h29DF);
    wait_valid();
    accept_one();
    respond(32'h1234_5678);
    check("t3_rdata_kept", rdata, 32'h4AFC_4E71);

    // Push into a full FIFO in the same cycle as an accept.
    for (int i = 0; i < 4; i++) push_req(16'(16'h0020 * i), 16'h2920);
    check("t4_full", full, 1'b1);
    pi_wr(3'd2, 16'h0050);
    req_ready    = 1'b1;
    pi_wr_strobe = 1'b1;
    pi_a         = 3'd3;
    pi_data_in   = 16'h2920;
    @(negedge sys_clk);
    req_ready    = 1'b0;
    pi_wr_strobe = 1'b0;
    check("t4_overflow_none", overflow, 1'b0);
    check("t4_full_kept", full, 1'b1);
    check("t4_inflight", req_valid, 1'b0);

    // Reset with one in flight and three queued.
    respond(32'h0);
    wait_valid();
    accept_one();
    nRESET = 1'b0;
    @(negedge sys_clk);
    nRESET = 1'b1;
    check("t5_req_valid", req_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_full", full, 1'b0);
    check("t5_overflow", overflow, 1'b0);
    check("t5_rdata", rdata, 32'h0);
    check("t5_req_addr", req_addr, 24'h0);
    check("t5_req_wdata", req_wdata, 32'h0);
    respond(32'hDEAD_BEEF);
    check("t5_stale_rdata", rdata, 32'h0);
    check("t5_stale_busy", busy, 1'b0);

    // Staging changes after a push do not touch queued entries.
    pi_wr(3'd0, 16'h1111);
    push_req(16'h0300, 16'h2930);
    pi_wr(3'd0, 16'h2222);
    check("t6_queued_wdata", req_wdata, 32'h0000_1111);
    check("t6_queued_addr", req_addr, 24'h300300);
    push_req(16'h0400, 16'h2930);
    accept_one();
    respond(32'h0);
    wait_valid();
    check("t6_second_wdata", req_wdata, 32'h0000_2222);
    check("t6_second_addr", req_addr, 24'h300400);
    accept_one();
    respond(32'h0);
    repeat (2) @(negedge sys_clk);
    check("t6_idle_busy", busy, 1'b0);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
